// File: rtl/cell_hist_acc.sv
// cell_hist_acc: per-cell 9-bin orientation histogram accumulator.
// Pixels (bin code, magnitude) are summed into the accumulate bank while the
// other bank drains the previous cell as a 9-beat valid/ready stream.
// Banks are zeroed beat-by-beat as they drain, so a bank re-enters the
// accumulate role already clear.
module cell_hist_acc #(
  parameter int MAG_W = 9,
  parameter int SUM_W = MAG_W + 6,
  parameter int NBIN  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [3:0]       i_code,
  input  logic [MAG_W-1:0] i_mag,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [3:0]       o_bin,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_last,
  output logic             o_ovf,
  output logic             o_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(NBIN - 1);
  localparam logic [3:0] MAX_CODE = 4'(NBIN - 1);

  // drain FSM and bank select
  logic [0:0] state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic       acc_sel_reg, acc_sel_next;

  // registered event pulses
  logic       ovf_reg, ovf_next;
  logic       err_reg, err_next;

  // cycle-level events
  logic       draining;
  logic       swap;
  logic       drop;
  logic       pix_ok;
  logic       beat_done;

  // both banks, flattened as [bank][bin]
  logic [1:0][NBIN-1:0][SUM_W-1:0] bank_q;
  logic [SUM_W-1:0]                drain_sum;

  // Decode the events of this cycle. i_last while draining drops the new
  // cell instead of swapping, so the running drain is never disturbed.
  always_comb begin
    draining  = (state_reg == ST_DRAIN);
    swap      = i_last && !draining;
    drop      = i_last && draining;
    pix_ok    = i_valid && (i_code <= MAX_CODE);
    beat_done = draining && o_ready;
  end

  // Next-state for the drain FSM, beat index and bank select
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    acc_sel_next = acc_sel_reg;
    if (!draining) begin
      if (i_last) begin
        state_next   = ST_DRAIN;
        idx_next     = 4'd0;
        acc_sel_next = ~acc_sel_reg;
      end
    end else if (o_ready) begin
      if (idx_reg == LAST_IDX) begin
        state_next = ST_IDLE;
      end else begin
        idx_next = idx_reg + 4'd1;
      end
    end
  end

  // Next values for the one-cycle status pulses
  always_comb begin
    ovf_next = drop;
    err_next = i_valid && (i_code > MAX_CODE);
  end

  // Register FSM, bank select and status pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= 4'd0;
      acc_sel_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      acc_sel_reg <= acc_sel_next;
      ovf_reg     <= ovf_next;
      err_reg     <= err_next;
    end
  end

  // One register per (bank, bin). A pixel arriving with i_last belongs to the
  // new cell, so the accumulate role is judged with acc_sel_next.
  genvar gb, gi;
  generate
    for (gb = 0; gb < 2; gb++) begin : g_bank
      for (gi = 0; gi < NBIN; gi++) begin : g_bin
        logic [SUM_W-1:0] cell_reg, cell_next;
        logic [SUM_W:0]   sum_wide;
        logic             hit;
        logic             is_acc;

        // Saturating accumulate, clear-on-drop, or clear-on-drain-beat
        always_comb begin
          hit       = pix_ok && (i_code == 4'(gi));
          is_acc    = (acc_sel_next == 1'(gb));
          sum_wide  = {1'b0, cell_reg} + {{(SUM_W + 1 - MAG_W){1'b0}}, i_mag};
          cell_next = cell_reg;
          if (is_acc) begin
            if (drop) begin
              cell_next = hit ? SUM_W'(i_mag) : '0;
            end else if (hit) begin
              cell_next = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
            end
          end else if (beat_done && (idx_reg == 4'(gi))) begin
            cell_next = '0;
          end
        end

        // Bank cell storage; reset discards both banks
        always_ff @(posedge clk) begin
          if (!rst) begin
            cell_reg <= '0;
          end else begin
            cell_reg <= cell_next;
          end
        end

        assign bank_q[gb][gi] = cell_reg;
      end
    end
  endgenerate

  // Select the current drain beat from the drain bank by beat index
  always_comb begin
    drain_sum = '0;
    for (int i = 0; i < NBIN; i++) begin
      if (idx_reg == 4'(i)) begin
        drain_sum = bank_q[~acc_sel_reg][i];
      end
    end
  end

  // Outputs are driven purely from registers; idle beats read as zero
  assign o_valid = (state_reg == ST_DRAIN);
  assign o_bin   = o_valid ? idx_reg : 4'd0;
  assign o_sum   = o_valid ? drain_sum : '0;
  assign o_last  = o_valid && (idx_reg == LAST_IDX);
  assign o_ovf   = ovf_reg;
  assign o_err   = err_reg;

endmodule

// File: tb/tb_cell_hist_acc.sv
// tb_cell_hist_acc: directed scenarios plus random traffic for cell_hist_acc.
module tb_cell_hist_acc;

  localparam int MAG_W   = 9;
  localparam int SUM_W   = MAG_W + 6;
  localparam int SUM_MAX = (1 << SUM_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic [3:0]       i_code = 4'd0;
  logic [MAG_W-1:0] i_mag = '0;
  logic             i_last = 1'b0;
  logic             o_valid;
  logic             o_ready = 1'b1;
  logic [3:0]       o_bin;
  logic [SUM_W-1:0] o_sum;
  logic             o_last;
  logic             o_ovf;
  logic             o_err;

  cell_hist_acc #(.MAG_W(MAG_W), .SUM_W(SUM_W), .NBIN(9)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_code(i_code), .i_mag(i_mag), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_bin(o_bin), .o_sum(o_sum),
    .o_last(o_last), .o_ovf(o_ovf), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int sum;
    int last;
  } beat_t;

  int    total_cnt = 0;
  int    bad_cnt   = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    cur[9];
  bit    exp_ovf = 1'b0;
  bit    exp_err = 1'b0;
  int    ovf_cnt = 0;
  int    err_cnt = 0;
  int    valid_cyc = 0;
  bit    toggle_ready = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: cells are plain bin arrays; a finished cell becomes 9 queued
  // beats, and the stream is busy exactly while beats remain queued.
  always @(negedge clk) begin
    bit busy;
    int s;
    if (exp_q.size() > 0) begin
      check("o_valid", o_valid, 1);
      check("o_bin", o_bin, exp_q[0].bin);
      check("o_sum", o_sum, exp_q[0].sum);
      check("o_last", o_last, (exp_q[0].bin == 8));
    end else begin
      check("o_valid", o_valid, 0);
      check("o_bin_idle", o_bin, 0);
      check("o_sum_idle", o_sum, 0);
      check("o_last_idle", o_last, 0);
    end
    check("o_ovf", o_ovf, exp_ovf);
    check("o_err", o_err, exp_err);

    if (o_valid && o_ready) got_q.push_back('{int'(o_bin), int'(o_sum), int'(o_last)});
    if (o_ovf) ovf_cnt++;
    if (o_err) err_cnt++;
    if (o_valid) valid_cyc++;

    exp_ovf = 1'b0;
    exp_err = 1'b0;
    if (!rst) begin
      exp_q.delete();
      foreach (cur[b]) cur[b] = 0;
    end else begin
      busy = (exp_q.size() > 0);
      if (busy && o_ready) void'(exp_q.pop_front());
      if (i_last) begin
        if (busy) exp_ovf = 1'b1;
        else for (int b = 0; b < 9; b++) exp_q.push_back('{b, cur[b], 0});
        foreach (cur[b]) cur[b] = 0;
      end
      if (i_valid) begin
        if (i_code <= 4'd8) begin
          s = cur[i_code] + int'(i_mag);
          cur[i_code] = (s > SUM_MAX) ? SUM_MAX : s;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_ready) o_ready = ~o_ready;
  endtask

  task automatic pix(int code, int mag);
    i_valid = 1'b1;
    i_code  = 4'(code);
    i_mag   = MAG_W'(mag);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic send_last();
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
  endtask

  task automatic wait_beats(int n, int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("drain_complete", got_q.size(), n);
  endtask

  task automatic check_hist(string tag, input int e[9]);
    check({tag, "_beats"}, got_q.size(), 9);
    for (int b = 0; b < 9; b++) begin
      if (b < got_q.size()) begin
        check({tag, "_bin"}, got_q[b].bin, b);
        check({tag, "_sum"}, got_q[b].sum, e[b]);
        check({tag, "_last"}, got_q[b].last, (b == 8));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[9];
    int hx[9];
    int hy[9];
    int c;
    int m;
    int k;

    // reset
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_bin", o_bin, 0);
    check("reset_o_sum", o_sum, 0);
    check("reset_o_last", o_last, 0);
    check("reset_o_ovf", o_ovf, 0);
    check("reset_o_err", o_err, 0);
    tick();
    $display("txn reset done");

    // basic cell
    for (int n = 0; n < 64; n++) pix(n % 9, 10);
    got_q.delete();
    valid_cyc = 0;
    send_last();
    wait_beats(9, 30);
    repeat (3) tick();
    e = '{80, 70, 70, 70, 70, 70, 70, 70, 70};
    check_hist("basic", e);
    check("basic_valid_cycles", valid_cyc, 9);
    $display("txn basic cell drained");

    // saturation
    for (int n = 0; n < 64; n++) pix(3, 511);
    got_q.delete();
    send_last();
    wait_beats(9, 30);
    e = '{0, 0, 0, 32704, 0, 0, 0, 0, 0};
    check_hist("width", e);
    $display("txn 64x511 drained");
    for (int n = 0; n < 264; n++) pix(3, 511);
    got_q.delete();
    send_last();
    wait_beats(9, 30);
    e = '{0, 0, 0, 32767, 0, 0, 0, 0, 0};
    check_hist("saturate", e);
    $display("txn 264x511 drained");

    // back-pressure and ping-pong
    foreach (hx[b]) hx[b] = 0;
    foreach (hy[b]) hy[b] = 0;
    for (int n = 0; n < 20; n++) begin
      c = $urandom_range(0, 8);
      m = $urandom_range(0, 511);
      hx[c] += m;
      pix(c, m);
    end
    toggle_ready = 1'b1;
    got_q.delete();
    send_last();
    for (int n = 0; n < 10; n++) begin
      c = $urandom_range(0, 8);
      m = $urandom_range(0, 511);
      hy[c] += m;
      pix(c, m);
    end
    wait_beats(9, 60);
    check_hist("pingpong_x", hx);
    $display("txn ping-pong cell x drained");
    got_q.delete();
    send_last();
    wait_beats(9, 60);
    check_hist("pingpong_y", hy);
    $display("txn ping-pong cell y drained");
    pix(4, 9);
    got_q.delete();
    send_last();
    wait_beats(9, 60);
    e = '{0, 0, 0, 0, 9, 0, 0, 0, 0};
    check_hist("reuse", e);
    toggle_ready = 1'b0;
    o_ready = 1'b1;
    $display("txn bank reuse drained");

    // overflow
    repeat (3) pix(1, 20);
    got_q.delete();
    ovf_cnt = 0;
    send_last();
    pix(7, 50);
    repeat (2) tick();
    send_last();
    repeat (4) pix(5, 3);
    wait_beats(9, 30);
    e = '{0, 60, 0, 0, 0, 0, 0, 0, 0};
    check_hist("ovf_first", e);
    check("ovf_pulses", ovf_cnt, 1);
    got_q.delete();
    send_last();
    wait_beats(9, 30);
    e = '{0, 0, 0, 0, 0, 12, 0, 0, 0};
    check_hist("ovf_third", e);
    $display("txn overflow sequence done");

    // simultaneous pixel+last, illegal code
    repeat (3) pix(2, 1);
    got_q.delete();
    err_cnt = 0;
    i_last = 1'b1;
    pix(2, 7);
    i_last = 1'b0;
    pix(12, 100);
    wait_beats(9, 30);
    e = '{0, 0, 3, 0, 0, 0, 0, 0, 0};
    check_hist("simul_old", e);
    check("err_pulses", err_cnt, 1);
    got_q.delete();
    send_last();
    wait_beats(9, 30);
    e = '{0, 0, 7, 0, 0, 0, 0, 0, 0};
    check_hist("simul_new", e);
    $display("txn simultaneous/illegal done");

    // reset mid-drain
    repeat (2) pix(6, 33);
    send_last();
    k = 0;
    while (!(o_valid && o_bin == 4'd4) && k < 30) begin
      tick();
      k++;
    end
    check("reach_beat4", o_bin, 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_sum", o_sum, 0);
    tick();
    pix(0, 5);
    got_q.delete();
    send_last();
    wait_beats(9, 30);
    e = '{5, 0, 0, 0, 0, 0, 0, 0, 0};
    check_hist("after_rst", e);
    $display("txn reset mid-drain done");

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      o_ready = ($urandom_range(0, 9) < 6);
      i_valid = ($urandom_range(0, 9) < 7);
      i_code  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      i_mag   = MAG_W'($urandom_range(0, 511));
      i_last  = ($urandom_range(0, 39) == 0);
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    o_ready = 1'b1;
    repeat (20) tick();
    $display("txn random traffic done");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
